// File: rtl/hsci_phy_bringup_ctrl.sv
// Bring-up and supervision FSM for one HSCI SelectIO PHY bank (PLL + lanes).
// Define HSCI_PHY_CTRL_LOCK_MONITOR_EN to re-sequence the bank when status drops in READY.
`timescale 1ns/1ps
module hsci_phy_bringup_ctrl #(
  parameter int unsigned NUM_RDY        = 8,
  parameter int unsigned RST_CYCLES     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
  input  logic               restart,
  input  logic               pll_locked,
  input  logic               rst_seq_done,
  input  logic [NUM_RDY-1:0] rdy_in,
  output logic               pll_reset,
  output logic               phy_ready,
  output logic               fail,
  output logic [2:0]         state,
  output logic [3:0]         retry_cnt
);

  localparam int unsigned TMR_MAX = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TW      = $clog2(TMR_MAX);
  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RESET     = 3'd1,
    WAIT_LOCK = 3'd2,
    WAIT_SEQ  = 3'd3,
    WAIT_RDY  = 3'd4,
    READY     = 3'd5,
    FAIL      = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [3:0]        retry_q, retry_d;
  logic              pll_reset_q, pll_reset_d;
  logic              phy_ready_q, phy_ready_d;
  logic              fail_q, fail_d;
  logic [1:0]        lock_sync_q;
  logic [1:0]        seq_sync_q;
  logic [NUM_RDY-1:0] rdy_meta_q, rdy_sync_q;
  logic              lock_s, seq_s, rdy_all;
  logic              reenter, error, timeout;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_sync_q <= '0;
      seq_sync_q  <= '0;
      rdy_meta_q  <= '0;
      rdy_sync_q  <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], pll_locked};
      seq_sync_q  <= {seq_sync_q[0], rst_seq_done};
      rdy_meta_q  <= rdy_in;
      rdy_sync_q  <= rdy_meta_q;
    end
  end

  assign lock_s  = lock_sync_q[1];
  assign seq_s   = seq_sync_q[1];
  assign rdy_all = &rdy_sync_q;
  assign timeout = (tmr_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    reenter = 1'b0;
    error   = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      retry_d = '0;
    end else if (restart) begin
      state_d = RESET;
      retry_d = '0;
      reenter = 1'b1;
    end else begin
      unique case (state_q)
        IDLE:      state_d = RESET;
        RESET:     if (tmr_q == RST_LAST) state_d = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_s)       state_d = WAIT_SEQ;
          else if (timeout) error   = 1'b1;
        end
        WAIT_SEQ: begin
          if (seq_s)                   state_d = WAIT_RDY;
          else if (!lock_s || timeout) error   = 1'b1;
        end
        WAIT_RDY: begin
          if (rdy_all)                          state_d = READY;
          else if (!lock_s || !seq_s || timeout) error  = 1'b1;
        end
        READY: begin
`ifdef HSCI_PHY_CTRL_LOCK_MONITOR_EN
          // Loss of status is a fresh bring-up, not a consumed retry.
          if (!(lock_s && seq_s && rdy_all)) begin
            state_d = RESET;
            retry_d = '0;
          end
`endif
        end
        FAIL:    state_d = FAIL;
        default: state_d = IDLE;
      endcase
      if (error) begin
        if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 4'd1;
          state_d = RESET;
        end else begin
          state_d = FAIL;
        end
      end
    end
  end

  // Timer saturates in the untimed states; in timed states a terminal count always exits.
  always_comb begin
    if ((state_d != state_q) || reenter) tmr_d = '0;
    else if (tmr_q != '1)                tmr_d = tmr_q + TW'(1);
    else                                 tmr_d = tmr_q;
  end

  assign pll_reset_d = (state_d == IDLE) || (state_d == RESET) || (state_d == FAIL);
  assign phy_ready_d = (state_d == READY);
  assign fail_d      = (state_d == FAIL);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      phy_ready_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      phy_ready_q <= phy_ready_d;
      fail_q      <= fail_d;
    end
  end

  assign state     = state_q;
  assign retry_cnt = retry_q;
  assign pll_reset = pll_reset_q;
  assign phy_ready = phy_ready_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_hsci_phy_bringup_ctrl.sv
// Bench for hsci_phy_bringup_ctrl: vector table, corner sequences and random run vs. a stage model.
`timescale 1ns/1ps
module tb_hsci_phy_bringup_ctrl;

  localparam int unsigned NR  = 8;
  localparam int unsigned RST = 16;
  localparam int unsigned TO  = 32;
  localparam int unsigned MR  = 2;

  localparam int M_IDLE = 0, M_RESET = 1, M_WL = 2, M_WR = 4, M_READY = 5, M_FAIL = 6;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          enable = 1'b0, restart = 1'b0;
  logic          pll_locked = 1'b0, rst_seq_done = 1'b0;
  logic [NR-1:0] rdy_in = '0;
  logic          pll_reset, phy_ready, fail;
  logic [2:0]    state;
  logic [3:0]    retry_cnt;

  hsci_phy_bringup_ctrl #(
    .NUM_RDY(NR), .RST_CYCLES(RST), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .restart(restart),
    .pll_locked(pll_locked), .rst_seq_done(rst_seq_done), .rdy_in(rdy_in),
    .pll_reset(pll_reset), .phy_ready(phy_ready), .fail(fail),
    .state(state), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic          rstn_v = 1'b1, en_v = 1'b0, rs_v = 1'b0, lk_v = 1'b0, sq_v = 1'b0;
  logic [NR-1:0] rd_v = '0;

  // Stage model: a bank walks lock -> seq -> rdy; each wait stage has one goal flag
  // and requires every earlier flag to remain set. Flags are seen 3 edges after driving.
  int       m_state = 0, m_age = 0, m_retry = 0;
  bit [2:0] hist[$];

  task automatic model_step();
    bit [2:0] vis;
    int       nxt, idx;
    bit       fresh, lost;
    if (!resetn) begin
      m_state = M_IDLE; m_age = 0; m_retry = 0; hist.delete();
      return;
    end
    hist.push_back({pll_locked, rst_seq_done, &rdy_in});
    if (hist.size() > 3) void'(hist.pop_front());
    vis   = (hist.size() == 3) ? hist[0] : 3'b000;
    nxt   = m_state;
    fresh = 1'b0;
    if (!enable) begin
      nxt = M_IDLE; m_retry = 0;
    end else if (restart) begin
      nxt = M_RESET; m_retry = 0; fresh = 1'b1;
    end else if (m_state == M_IDLE) begin
      nxt = M_RESET;
    end else if (m_state == M_RESET) begin
      if (m_age == int'(RST) - 1) nxt = M_WL;
    end else if (m_state >= M_WL && m_state <= M_WR) begin
      idx  = M_WR - m_state;
      lost = 1'b0;
      for (int b = idx + 1; b < 3; b++) if (!vis[b]) lost = 1'b1;
      if (vis[idx]) nxt = m_state + 1;
      else if (lost || m_age == int'(TO) - 1) begin
        if (m_retry < int'(MR)) begin m_retry++; nxt = M_RESET; end
        else nxt = M_FAIL;
      end
    end else if (m_state == M_READY) begin
`ifdef HSCI_PHY_CTRL_LOCK_MONITOR_EN
      if (vis != 3'b111) begin nxt = M_RESET; m_retry = 0; end
`endif
    end
    m_age   = (nxt != m_state || fresh) ? 0 : m_age + 1;
    m_state = nxt;
  endtask

  function automatic logic [9:0] pack(input int st, input int rc);
    return {3'(st), 4'(rc), (st == M_IDLE || st == M_RESET || st == M_FAIL),
            (st == M_READY), (st == M_FAIL)};
  endfunction

  task automatic chk(input string name, input logic [9:0] exp);
    logic [9:0] act;
    act = {state, retry_cnt, pll_reset, phy_ready, fail};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got state=%0d retry=%0d pll_reset=%0b phy_ready=%0b fail=%0b, want state=%0d retry=%0d pll_reset=%0b phy_ready=%0b fail=%0b",
               name, cyc, act[9:7], act[6:3], act[2], act[1], act[0],
               exp[9:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      resetn = rstn_v; enable = en_v; restart = rs_v;
      pll_locked = lk_v; rst_seq_done = sq_v; rdy_in = rd_v;
      @(negedge clk);
      chk("model", pack(m_state, m_retry));
    end
  endtask

  task automatic start_fresh(input bit lk, input bit sq, input bit rd);
    en_v = 0; rs_v = 0; lk_v = 0; sq_v = 0; rd_v = '0;
    tick(4);
    en_v = 1; lk_v = lk; sq_v = sq; rd_v = rd ? '1 : '0;
  endtask

  typedef struct {
    bit en, rs, lk, sq, rd;
    int n;
    int st, rc;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t v(input bit en, input bit rs, input bit lk, input bit sq,
                             input bit rd, input int n, input int st, input int rc);
    vec_t r;
    r.en = en; r.rs = rs; r.lk = lk; r.sq = sq; r.rd = rd; r.n = n; r.st = st; r.rc = rc;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, prev_st, k;
    int rlog[$];

    // Nominal bring-up, cycle 0 = first cycle enable is driven high.
    vecs.push_back(v(1,0,0,0,0, 1, 0,0));
    vecs.push_back(v(1,0,0,0,0, 1, 1,0));
    vecs.push_back(v(1,0,0,0,0,15, 1,0));
    vecs.push_back(v(1,0,0,0,0, 1, 2,0));
    vecs.push_back(v(1,0,0,0,0,13, 2,0));
    vecs.push_back(v(1,0,1,0,0, 3, 2,0));
    vecs.push_back(v(1,0,1,0,0, 1, 3,0));
    vecs.push_back(v(1,0,1,1,0, 3, 3,0));
    vecs.push_back(v(1,0,1,1,0, 1, 4,0));
    vecs.push_back(v(1,0,1,1,1, 3, 4,0));
    vecs.push_back(v(1,0,1,1,1, 1, 5,0));
    vecs.push_back(v(1,0,1,1,1,20, 5,0));
    // Restart from READY, then again mid-RESET: pulse must restart in full.
    vecs.push_back(v(1,1,1,1,1, 1, 5,0));
    vecs.push_back(v(1,0,1,1,1, 1, 1,0));
    vecs.push_back(v(1,0,1,1,1, 5, 1,0));
    vecs.push_back(v(1,1,1,1,1, 1, 1,0));
    vecs.push_back(v(1,0,1,1,1,16, 1,0));
    vecs.push_back(v(1,0,1,1,1, 1, 2,0));
    vecs.push_back(v(1,0,1,1,1, 3, 5,0));

    #2;
    resetn = 1'b0; rstn_v = 1'b0;
    #1;
    chk("reset_async", pack(M_IDLE, 0));
    tick(2);
    chk("reset_hold", pack(M_IDLE, 0));
    rstn_v = 1'b1;
    tick(1);

    start_fresh(0, 0, 0);
    foreach (vecs[i]) begin
      en_v = vecs[i].en; rs_v = vecs[i].rs; lk_v = vecs[i].lk; sq_v = vecs[i].sq;
      rd_v = vecs[i].rd ? '1 : '0;
      tick(vecs[i].n);
      chk($sformatf("vec%0d", i), pack(vecs[i].st, vecs[i].rc));
    end
    rs_v = 0;

    // Lock timeout with retries: three RESET pulses then FAIL.
    start_fresh(0, 0, 0);
    pulses = 0; prev_st = M_IDLE; k = 0;
    while (k < 400 && state != 3'(M_FAIL)) begin
      tick(1);
      if (state == 3'(M_RESET) && prev_st != M_RESET) begin
        pulses++; rlog.push_back(int'(retry_cnt));
      end
      prev_st = int'(state);
      k++;
    end
    chk_int("to_pulses", pulses, 3);
    chk_int("to_retry_seq", (rlog.size() == 3) ? (rlog[0] * 100 + rlog[1] * 10 + rlog[2]) : -1, 12);
    chk("to_fail", pack(M_FAIL, 2));
    tick(5);
    chk("to_fail_hold", pack(M_FAIL, 2));
    rs_v = 1; tick(1);
    rs_v = 0; tick(1);
    chk("to_restart", pack(M_RESET, 0));

    // Boundary race: lock seen on the last budget cycle wins; one cycle later is an error.
    start_fresh(0, 0, 0);
    tick(46); lk_v = 1; tick(3);
    chk("race_pre", pack(M_WL, 0));
    tick(1);
    chk("race_win", pack(3, 0));
    start_fresh(0, 0, 0);
    tick(47); lk_v = 1; tick(2);
    chk("race_late_pre", pack(M_WL, 0));
    tick(1);
    chk("race_late", pack(M_RESET, 1));

    // Lock lost in WAIT_RDY.
    start_fresh(1, 1, 0);
    tick(26);
    chk("wrdy_reached", pack(M_WR, 0));
    lk_v = 0; tick(1); tick(2);
    chk("wrdy_drop_pre", pack(M_WR, 0));
    tick(1);
    chk("wrdy_drop", pack(M_RESET, 1));

    // Lock lost in READY.
    start_fresh(1, 1, 1);
    tick(26);
    chk("ready_reached", pack(M_READY, 0));
    lk_v = 0; tick(1); tick(2);
    chk("ready_drop_pre", pack(M_READY, 0));
    tick(1);
`ifdef HSCI_PHY_CTRL_LOCK_MONITOR_EN
    chk("ready_drop_mon", pack(M_RESET, 0));
`else
    chk("ready_drop_sticky", pack(M_READY, 0));
    tick(10);
    chk("ready_sticky_hold", pack(M_READY, 0));
`endif

    // Async reset mid-WAIT_SEQ.
    start_fresh(1, 0, 0);
    tick(24);
    chk("wseq_reached", pack(3, 0));
    #2;
    resetn = 1'b0; rstn_v = 1'b0;
    #1;
    chk("areset_now", pack(M_IDLE, 0));
    tick(3);
    rstn_v = 1'b1; en_v = 0;
    tick(5);
    chk("areset_idle", pack(M_IDLE, 0));
    en_v = 1; tick(1);
    chk("areset_en_drive", pack(M_IDLE, 0));
    tick(1);
    chk("areset_en_seen", pack(M_RESET, 0));

    // Random run against the model.
    en_v = 1; rs_v = 0;
    for (int i = 0; i < 3000; i++) begin
      en_v = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      rs_v = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 39) == 0) lk_v = ~lk_v;
      if ($urandom_range(0, 39) == 0) sq_v = ~sq_v;
      if ($urandom_range(0, 29) == 0) rd_v = '1;
      if ($urandom_range(0, 59) == 0) rd_v[$urandom_range(0, NR - 1)] ^= 1'b1;
      tick(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
